// File: rtl/ercm8_1.sv
// ercm8_1: registered 8x8 unsigned multiplier whose low columns (0..6) can each be
// collapsed to an OR bit at runtime; the rest is a carry-save tree plus a final adder.
module ercm8_1 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  dat_in_a,
   input  logic [7:0]  dat_in_b,
   input  logic [6:0]  mask,
   output logic [15:0] dat_o
);
   logic [7:0]  a_r, b_r;
   logic [6:0]  m_r;
   logic [6:0]  col_or;
   logic [15:0] row [20];
   logic [15:0] prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         m_r   <= '0;
         dat_o <= '0;
      end else begin
         a_r   <= dat_in_a;
         b_r   <= dat_in_b;
         m_r   <= mask;
         dat_o <= prod;
      end
   end

   // Rows 0..7 are the shifted partial products; a masked column keeps only its OR bit,
   // parked in row 0, so it still absorbs carries from the exact columns below it.
   // Rows 8..19 come from six 3:2 compressor stages; rows 18/19 feed the final adder.
   always_comb begin
      col_or = '0;
      for (int k = 0; k < 7; k++)
         for (int i = 0; i <= k; i++)
            col_or[k] = col_or[k] | (a_r[i] & b_r[k-i]);
      for (int i = 0; i < 20; i++)
         row[i] = '0;
      for (int i = 0; i < 8; i++)
         row[i] = 16'(a_r & {8{b_r[i]}}) << i;
      for (int k = 0; k < 7; k++)
         if (m_r[k]) begin
            for (int i = 1; i < 8; i++)
               row[i][k] = 1'b0;
            row[0][k] = col_or[k];
         end
      for (int c = 0; c < 6; c++) begin
         row[8+2*c] = row[3*c] ^ row[3*c+1] ^ row[3*c+2];
         row[9+2*c] = ((row[3*c] & row[3*c+1]) | (row[3*c] & row[3*c+2])
                      | (row[3*c+1] & row[3*c+2])) << 1;
      end
      prod = row[18] + row[19];
   end
endmodule

// File: tb/tb_ercm8_1.sv
// tb_ercm8_1: random and directed checks of ercm8_1 against a column-count reference model.
module tb_ercm8_1;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  a = '0, b = '0;
   logic [6:0]  mask = '0;
   logic [15:0] dat_o;
   int          checks = 0, fails = 0;
   logic [15:0] exp_q [$];
   string       tag_q [$];

   ercm8_1 dut (.clk(clk), .rst_n(rst_n), .dat_in_a(a), .dat_in_b(b), .mask(mask), .dat_o(dat_o));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Sum each weight-k column as a bit count, or as a single presence bit when masked.
   function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic [6:0] m);
      int s = 0;
      logic [14:0] mw = {8'b0, m};
      for (int k = 0; k < 15; k++) begin
         int n = 0;
         for (int i = 0; i < 8; i++)
            if (k - i >= 0 && k - i <= 7) n += int'(x[i] & y[k-i]);
         s += (mw[k] ? int'(n != 0) : n) << k;
      end
      return 16'(s);
   endfunction

   // Each call drives one operand set at a falling edge; the result is due two edges later.
   task automatic apply(input logic [7:0] x, input logic [7:0] y, input logic [6:0] m,
                        input logic [15:0] exp, input string tag);
      @(negedge clk);
      if (exp_q.size() == 2) chk(tag_q.pop_front(), dat_o, exp_q.pop_front());
      a = x; b = y; mask = m;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   task automatic restart();
      a = '0; b = '0; mask = '0;
      rst_n = 1'b1;
      exp_q.delete(); tag_q.delete();
      exp_q.push_back(16'd0); exp_q.push_back(16'd0);
      tag_q.push_back("post_rst_0"); tag_q.push_back("post_rst_1");
   endtask

   initial begin
      a = 8'hAA; b = 8'h55; mask = 7'h15;
      repeat (2) @(negedge clk);
      chk("rst_initial", dat_o, 16'd0);
      restart();
      apply(8'd9, 8'd9, 7'h00, 16'd81, "pre_rst_a");
      apply(8'd200, 8'd100, 7'h00, 16'd20000, "pre_rst_b");
      apply(8'd3, 8'd3, 7'h00, 16'd9, "pre_rst_c");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", dat_o, 16'd0);
      @(negedge clk);
      chk("rst_held", dat_o, 16'd0);
      restart();
      apply(8'd5, 8'd7, 7'h00, 16'd35, "first_after_rst");
      apply(8'd255, 8'd255, 7'h00, 16'd65025, "exact_255x255");
      apply(8'd0, 8'd200, 7'h00, 16'd0, "exact_0x200");
      apply(8'd128, 8'd2, 7'h00, 16'd256, "exact_128x2");
      apply(8'd1, 8'd1, 7'h00, 16'd1, "exact_1x1");
      apply(8'd3, 8'd3, 7'h01, 16'd9, "mask01_3x3");
      apply(8'd3, 8'd3, 7'h02, 16'd7, "mask02_3x3");
      apply(8'd3, 8'd3, 7'h04, 16'd9, "mask04_3x3");
      apply(8'd255, 8'd255, 7'h7F, 16'd64383, "mask7f_255x255");
      apply(8'd255, 8'd255, 7'h55, model(8'd255, 8'd255, 7'h55), "mask55_255x255");
      apply(8'd170, 8'd85, 7'h2A, model(8'd170, 8'd85, 7'h2A), "mask2a_170x85");
      for (int n = 0; n < 10000; n++) begin
         logic [7:0] x, y;
         logic [6:0] m;
         x = 8'($urandom);
         y = 8'($urandom);
         m = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
         if (m == 7'h00) apply(x, y, m, 16'(int'(x) * int'(y)), "rand_exact");
         else            apply(x, y, m, model(x, y, m), "rand_masked");
      end
      apply(8'd0, 8'd0, 7'h00, 16'd0, "flush_0");
      apply(8'd0, 8'd0, 7'h00, 16'd0, "flush_1");
      apply(8'd0, 8'd0, 7'h00, 16'd0, "flush_2");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
